// File: rtl/sodor5_commit_checker_if.sv
// Register-writeback event bus feeding the commit checker.
// Carries one writeback stream from the core under test (dut_*) and one
// from the reference model (ref_*). Each stream is valid / rd / data.
//   master : the producer of both streams (core wrapper or testbench)
//   slave  : the commit checker
interface sodor5_commit_checker_if #(
    parameter int WORD_SIZE = 32
);
    logic                 dut_wb_valid;
    logic [4:0]           dut_wb_rd;
    logic [WORD_SIZE-1:0] dut_wb_data;
    logic                 ref_wb_valid;
    logic [4:0]           ref_wb_rd;
    logic [WORD_SIZE-1:0] ref_wb_data;

    modport master (
        output dut_wb_valid, dut_wb_rd, dut_wb_data,
        output ref_wb_valid, ref_wb_rd, ref_wb_data
    );

    modport slave (
        input dut_wb_valid, dut_wb_rd, dut_wb_data,
        input ref_wb_valid, ref_wb_rd, ref_wb_data
    );
endinterface

// File: rtl/sodor5_commit_checker.sv
// Commit-stream scoreboard for the sodor5 verification bench.
// Queues writeback events from the core and from the reference model in two
// FIFOs, compares them in order and latches the first mismatch, overflow or
// stall, then freezes until reset.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   wb (slave)            : dut_wb_* and ref_wb_* writeback streams
//   match_count           : number of matching compares (saturating)
//   error / err_code      : sticky error flag, 0 none 1 mismatch 2 overflow 3 timeout
//   err_index             : match_count at the failure
//   err_{dut,ref}_{rd,data}: FIFO head entries captured at the failure
//   dut_level, ref_level  : FIFO occupancies
module sodor5_commit_checker #(
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 64,
    parameter int WORD_SIZE = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    sodor5_commit_checker_if.slave     wb,
    output logic [31:0]                match_count,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [31:0]                err_index,
    output logic [4:0]                 err_dut_rd,
    output logic [4:0]                 err_ref_rd,
    output logic [WORD_SIZE-1:0]       err_dut_data,
    output logic [WORD_SIZE-1:0]       err_ref_data,
    output logic [$clog2(DEPTH):0]     dut_level,
    output logic [$clog2(DEPTH):0]     ref_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 5 + WORD_SIZE;          // {rd, data}
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_RUN = 1'b0, ST_FAIL = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [31:0]    match_count_q, match_count_d;
    logic [SW-1:0]  stall_q, stall_d;
    logic           error_q, error_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [31:0]    err_index_q, err_index_d;
    logic [EW-1:0]  err_dut_q, err_dut_d;
    logic [EW-1:0]  err_ref_q, err_ref_d;

    // Index 0 is the core stream, index 1 the reference stream.
    logic [1:0]     in_valid;
    logic [EW-1:0]  in_entry [2];
    logic [EW-1:0]  head     [2];
    logic [LW-1:0]  level    [2];
    logic [1:0]     nonempty, full, push, pop;
    logic           cmp, lone;
    logic [1:0]     fail_code;

    // Writes to x0 are architecturally invisible, so they are never queued.
    assign in_valid[0] = wb.dut_wb_valid && (wb.dut_wb_rd != 5'd0);
    assign in_valid[1] = wb.ref_wb_valid && (wb.ref_wb_rd != 5'd0);
    assign in_entry[0] = {wb.dut_wb_rd, wb.dut_wb_data};
    assign in_entry[1] = {wb.ref_wb_rd, wb.ref_wb_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [EW-1:0] mem_q [DEPTH];
            logic [AW-1:0] wr_ptr_q, wr_ptr_d;
            logic [AW-1:0] rd_ptr_q, rd_ptr_d;
            logic [LW-1:0] level_q, level_d;

            // Empty side reads as zeros so failure capture needs no extra mux.
            assign head[gi]  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
            assign level[gi] = level_q;

            // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                level_d  = level_q;
                if (push[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop[gi])  rd_ptr_d = rd_ptr_q + 1'b1;
                case ({push[gi], pop[gi]})
                    2'b10:   level_d = level_q + 1'b1;
                    2'b01:   level_d = level_q - 1'b1;
                    default: level_d = level_q;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    level_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    level_q  <= level_d;
                end
            end

            // Storage has no reset; the level counter defines what is valid.
            always_ff @(posedge clk) begin
                if (push[gi]) mem_q[wr_ptr_q] <= in_entry[gi];
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (level[i] != '0);
            full[i]     = (level[i] == LW'(DEPTH));
        end
        cmp  = nonempty[0] && nonempty[1];
        lone = nonempty[0] ^ nonempty[1];
    end

    always_comb begin
        state_d       = state_q;
        match_count_d = match_count_q;
        stall_d       = stall_q;
        error_d       = error_q;
        err_code_d    = err_code_q;
        err_index_d   = err_index_q;
        err_dut_d     = err_dut_q;
        err_ref_d     = err_ref_q;
        push          = '0;
        pop           = '0;
        fail_code     = 2'd0;

        if (state_q == ST_RUN) begin
            // Priority: mismatch, then overflow, then timeout. A pop only
            // happens on a compare, so !cmp means "no pop on this side".
            if (cmp && (head[0] != head[1]))
                fail_code = 2'd1;
            else if ((in_valid[0] && full[0] && !cmp) || (in_valid[1] && full[1] && !cmp))
                fail_code = 2'd2;
            else if (lone && (stall_q == SW'(TIMEOUT - 1)))
                fail_code = 2'd3;

            if (fail_code != 2'd0) begin
                // Failure edge moves nothing: the heads stay for inspection.
                state_d     = ST_FAIL;
                error_d     = 1'b1;
                err_code_d  = fail_code;
                err_index_d = match_count_q;
                err_dut_d   = head[0];
                err_ref_d   = head[1];
            end else begin
                push = in_valid;
                pop  = {cmp, cmp};
                if (cmp && (match_count_q != 32'hFFFF_FFFF))
                    match_count_d = match_count_q + 32'd1;
                stall_d = lone ? stall_q + 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            match_count_q <= '0;
            stall_q       <= '0;
            error_q       <= 1'b0;
            err_code_q    <= '0;
            err_index_q   <= '0;
            err_dut_q     <= '0;
            err_ref_q     <= '0;
        end else begin
            state_q       <= state_d;
            match_count_q <= match_count_d;
            stall_q       <= stall_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
            err_index_q   <= err_index_d;
            err_dut_q     <= err_dut_d;
            err_ref_q     <= err_ref_d;
        end
    end

    assign match_count  = match_count_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign err_index    = err_index_q;
    assign err_dut_rd   = err_dut_q[EW-1 -: 5];
    assign err_ref_rd   = err_ref_q[EW-1 -: 5];
    assign err_dut_data = err_dut_q[WORD_SIZE-1:0];
    assign err_ref_data = err_ref_q[WORD_SIZE-1:0];
    assign dut_level    = level[0];
    assign ref_level    = level[1];
endmodule

// File: tb/tb_sodor5_commit_checker.sv
module tb_sodor5_commit_checker;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int WS      = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] match_count;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] err_index;
    logic [4:0]  err_dut_rd, err_ref_rd;
    logic [31:0] err_dut_data, err_ref_data;
    logic [3:0]  dut_level, ref_level;

    sodor5_commit_checker_if #(.WORD_SIZE(WS)) bus ();

    sodor5_commit_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .WORD_SIZE(WS)) dut (
        .clk(clk), .reset(reset), .wb(bus),
        .match_count(match_count), .error(error), .err_code(err_code),
        .err_index(err_index), .err_dut_rd(err_dut_rd), .err_ref_rd(err_ref_rd),
        .err_dut_data(err_dut_data), .err_ref_data(err_ref_data),
        .dut_level(dut_level), .ref_level(ref_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (queues of {rd,data}) ----------------
    logic [36:0] qd[$];
    logic [36:0] qr[$];
    longint      m_match;
    int          m_stall;
    bit          m_failed;
    int          m_code;
    longint      m_idx;
    logic [36:0] m_ed, m_er;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit dv, input logic [4:0] drd, input logic [31:0] dd,
                              input bit rv, input logic [4:0] rrd, input logic [31:0] rdd);
        int nd, nr, code;
        bit both, single, pd, pr;
        logic [36:0] hd, hr;
        if (r) begin
            qd.delete(); qr.delete();
            m_match = 0; m_stall = 0; m_failed = 0; m_code = 0; m_idx = 0; m_ed = '0; m_er = '0;
            return;
        end
        if (m_failed) return;
        nd = qd.size(); nr = qr.size();
        both   = (nd > 0) && (nr > 0);
        single = (nd > 0) != (nr > 0);
        pd = dv && (drd != 0);
        pr = rv && (rrd != 0);
        hd = (nd > 0) ? qd[0] : '0;
        hr = (nr > 0) ? qr[0] : '0;
        code = 0;
        if (both && hd != hr) code = 1;
        else if (!both && ((pd && nd == DEPTH) || (pr && nr == DEPTH))) code = 2;
        else if (single && m_stall + 1 == TIMEOUT) code = 3;
        if (code != 0) begin
            m_failed = 1; m_code = code; m_idx = m_match; m_ed = hd; m_er = hr;
        end else begin
            if (both) begin
                void'(qd.pop_front()); void'(qr.pop_front());
                if (m_match < 64'hFFFF_FFFF) m_match++;
            end
            if (pd) qd.push_back({drd, dd});
            if (pr) qr.push_back({rrd, rdd});
            m_stall = single ? m_stall + 1 : 0;
        end
    endtask

    task automatic check_model();
        chk("match_count", match_count, m_match);
        chk("error", error, m_failed);
        chk("err_code", err_code, m_code);
        chk("err_index", err_index, m_idx);
        chk("err_dut_rd", err_dut_rd, m_ed[36:32]);
        chk("err_ref_rd", err_ref_rd, m_er[36:32]);
        chk("err_dut_data", err_dut_data, m_ed[31:0]);
        chk("err_ref_data", err_ref_data, m_er[31:0]);
        chk("dut_level", dut_level, qd.size());
        chk("ref_level", ref_level, qr.size());
    endtask

    // Drive one cycle of inputs, advance one edge, step model, check.
    task automatic tick(input bit r, input bit dv, input logic [4:0] drd, input logic [31:0] dd,
                        input bit rv, input logic [4:0] rrd, input logic [31:0] rdd);
        reset = r;
        bus.dut_wb_valid = dv; bus.dut_wb_rd = drd; bus.dut_wb_data = dd;
        bus.ref_wb_valid = rv; bus.ref_wb_rd = rrd; bus.ref_wb_data = rdd;
        @(posedge clk);
        #1;
        model_step(r, dv, drd, dd, rv, rrd, rdd);
        check_model();
    endtask

    task automatic idle();
        tick(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          dv;
        logic [4:0]  drd;
        logic [31:0] dd;
        bit          rv;
        logic [4:0]  rrd;
        logic [31:0] rdd;
        int          e_match;
        bit          e_err;
        int          e_code;
        int          e_dl;
        int          e_rl;
    } vec_t;

    vec_t vt[13];

    int          peak;
    int          pct_d, pct_r;
    int          di, ri;
    logic [4:0]  ev_rd [400];
    logic [31:0] ev_d  [400];
    logic [31:0] flip;

    initial begin
        reset = 1'b1;
        bus.dut_wb_valid = 0; bus.dut_wb_rd = 0; bus.dut_wb_data = 0;
        bus.ref_wb_valid = 0; bus.ref_wb_rd = 0; bus.ref_wb_data = 0;

        //        rst dv drd dd            rv rrd rdd           match err code dl rl
        vt[0]  = '{1, 0, 0, 0,            0, 0, 0,             0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 5, 32'h1234,     1, 5, 32'h1234,      0, 0, 0, 1, 1};
        vt[2]  = '{0, 1, 7, 32'hdeadbeef, 1, 7, 32'hdeadbeef,  1, 0, 0, 1, 1};
        vt[3]  = '{0, 0, 0, 0,            0, 0, 0,             2, 0, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 0,            0, 0, 0,             2, 0, 0, 0, 0};
        vt[5]  = '{0, 1, 0, 32'h77,       1, 0, 32'h66,        2, 0, 0, 0, 0};
        vt[6]  = '{0, 1, 9, 32'h55,       0, 0, 0,             2, 0, 0, 1, 0};
        vt[7]  = '{0, 0, 0, 0,            1, 9, 32'h55,        2, 0, 0, 1, 1};
        vt[8]  = '{0, 0, 0, 0,            0, 0, 0,             3, 0, 0, 0, 0};
        vt[9]  = '{0, 1, 1, 32'ha,        1, 1, 32'hb,         3, 0, 0, 1, 1};
        vt[10] = '{0, 0, 0, 0,            0, 0, 0,             3, 1, 1, 1, 1};
        vt[11] = '{0, 1, 2, 32'h3,        1, 2, 32'h3,         3, 1, 1, 1, 1};
        vt[12] = '{1, 1, 2, 32'h3,        1, 2, 32'h3,         0, 0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            tick(vt[i].rst, vt[i].dv, vt[i].drd, vt[i].dd, vt[i].rv, vt[i].rrd, vt[i].rdd);
            chk($sformatf("vec%0d match_count", i), match_count, vt[i].e_match);
            chk($sformatf("vec%0d error", i), error, vt[i].e_err);
            chk($sformatf("vec%0d err_code", i), err_code, vt[i].e_code);
            chk($sformatf("vec%0d dut_level", i), dut_level, vt[i].e_dl);
            chk($sformatf("vec%0d ref_level", i), ref_level, vt[i].e_rl);
            $display("vec %0d: match=%0d error=%0d code=%0d levels=%0d/%0d",
                     i, match_count, error, err_code, dut_level, ref_level);
        end

        // ---- skewed streams: dut cycles 0-3, ref cycles 10-13 ----
        tick(1, 0, 0, 0, 0, 0, 0);
        peak = 0;
        for (int c = 0; c < 15; c++) begin
            if (c < 4)
                tick(0, 1, 5'(c + 1), 32'h100 + c, 0, 0, 0);
            else if (c >= 10 && c < 14)
                tick(0, 0, 0, 0, 1, 5'(c - 9), 32'h100 + c - 10);
            else
                idle();
            if (int'(dut_level) > peak) peak = int'(dut_level);
        end
        chk("skew peak dut_level", peak, 4);
        chk("skew match_count", match_count, 4);
        chk("skew error", error, 0);
        $display("skew: peak=%0d match=%0d error=%0d", peak, match_count, error);

        // ---- mismatch on third event, then 20 frozen cycles ----
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 3, 32'h1, 1, 3, 32'h1);
        tick(0, 1, 3, 32'h2, 1, 3, 32'h2);
        tick(0, 1, 3, 32'h10, 1, 3, 32'h11);
        idle();
        for (int c = 0; c < 21; c++) begin
            chk("mism err_code", err_code, 1);
            chk("mism err_index", err_index, 2);
            chk("mism err_dut_data", err_dut_data, 32'h10);
            chk("mism err_ref_data", err_ref_data, 32'h11);
            chk("mism match_count", match_count, 2);
            chk("mism dut_level", dut_level, 1);
            if (c < 20) tick(0, 1, 5'($urandom_range(31)), $urandom, 1, 5'($urandom_range(31)), $urandom);
        end
        $display("mismatch: code=%0d index=%0d dut=%0h ref=%0h", err_code, err_index, err_dut_data, err_ref_data);

        // ---- overflow: 9 dut pushes, no ref ----
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 9; c++) begin
            tick(0, 1, 5'(c + 1), 32'h200 + c, 0, 0, 0);
            chk("ovf err_code", err_code, (c == 8) ? 2 : 0);
        end
        chk("ovf dut_level", dut_level, 8);
        chk("ovf err_dut_rd", err_dut_rd, 1);
        $display("overflow: code=%0d dut_level=%0d", err_code, dut_level);

        // ---- x0 filtering and timeout ----
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 32'h99);
        chk("x0 ref_level", ref_level, 0);
        tick(0, 1, 4, 32'h44, 0, 0, 0);
        chk("to dut_level", dut_level, 1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            idle();
            chk("to ref_level", ref_level, 0);
            if (k >= TIMEOUT - 1) chk($sformatf("to err_code k=%0d", k), err_code, (k == TIMEOUT) ? 3 : 0);
        end
        chk("to err_ref_rd", err_ref_rd, 0);
        chk("to err_dut_rd", err_dut_rd, 4);
        $display("timeout: code=%0d err_dut_rd=%0d err_ref_rd=%0d", err_code, err_dut_rd, err_ref_rd);

        // ---- reset mid-FAIL ----
        tick(1, 0, 0, 0, 0, 0, 0);
        chk("rst error", error, 0);
        chk("rst err_code", err_code, 0);
        chk("rst err_dut_rd", err_dut_rd, 0);
        chk("rst dut_level", dut_level, 0);
        tick(0, 1, 6, 32'h66, 1, 6, 32'h66);
        idle();
        chk("rst pair match_count", match_count, 1);
        chk("rst pair error", error, 0);
        $display("reset mid-fail: match=%0d error=%0d", match_count, error);

        // ---- randomized streams against the model ----
        for (int seg = 0; seg < 4; seg++) begin
            pct_d = (seg == 1) ? 75 : (seg == 3) ? 90 : 50;
            pct_r = (seg == 1) ? 30 : (seg == 3) ? 90 : 50;
            for (int i = 0; i < 400; i++) begin
                ev_rd[i] = 5'($urandom_range(31));
                ev_d[i]  = $urandom;
            end
            di = 0; ri = 0;
            tick(1, 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 300; c++) begin
                flip = (seg == 2 && $urandom_range(149) == 0) ? 32'h1 : 32'h0;
                tick(0, $urandom_range(99) < pct_d, ev_rd[di % 400], ev_d[di % 400],
                        $urandom_range(99) < pct_r, ev_rd[ri % 400], ev_d[ri % 400] ^ flip);
                if (bus.dut_wb_valid) di++;
                if (bus.ref_wb_valid) ri++;
            end
            $display("random seg %0d: match=%0d error=%0d code=%0d levels=%0d/%0d",
                     seg, match_count, error, err_code, dut_level, ref_level);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sodor5_commit_checker.md
# sodor5_commit_checker

Scoreboard for the sodor5 verification bench. It receives register-writeback events from the core under test and from the sodor5 reference model, and queues each stream in its own FIFO. It compares the two streams in order and latches the first divergence, FIFO overflow or stall. It sits beside `sodor5_verif`, downstream of the random instruction stream driven into `io_imem_resp_bits_data`.

## Interface
Parameters:
- `DEPTH`, 8: entries per FIFO; must be a power of two, at least 2.
- `TIMEOUT`, 64: cycles one stream may lead the other with no compare before a stall error.
- `WORD_SIZE`, 32: data width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `dut_wb_valid`  in  1  core retires a register write this cycle.
- `dut_wb_rd`  in  5  destination register of the core write.
- `dut_wb_data`  in  WORD_SIZE  write data from the core.
- `ref_wb_valid`, `ref_wb_rd`, `ref_wb_data`  in  1/5/WORD_SIZE  same three signals from the reference model.
- `match_count`  out  32  number of completed compares that matched.
- `error`  out  1  sticky; set when any failure is detected.
- `err_code`  out  2  0 none, 1 mismatch, 2 overflow, 3 timeout.
- `err_index`  out  32  compare number at the failure; equals `match_count` at that moment.
- `err_dut_rd`, `err_ref_rd`  out  5  rd values at the FIFO heads at failure.
- `err_dut_data`, `err_ref_data`  out  WORD_SIZE  data values at the FIFO heads at failure.
- `dut_level`, `ref_level`  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- Filtering: a valid event with rd==0 is dropped and never pushed.
- Two FIFOs, each with registered storage and its own read/write pointers.
  - Pointers wrap modulo DEPTH.
  - Level is tracked in a separate counter.
- State machine has two states, RUN and FAIL. Reset enters RUN.
- RUN, compare: when both FIFOs are non-empty, pop both heads in the same cycle and compare {rd, data}.
  - Equal: `match_count` increments by 1.
  - Unequal: go to FAIL with code 1.
- RUN, overflow: a push into a FIFO that is full, with no pop of that FIFO in the same cycle, goes to FAIL with code 2. The pushed event is discarded.
- RUN, push into a full FIFO while it pops in the same cycle: legal. Level stays DEPTH.
- RUN, stall counter:
  - Increments each cycle that exactly one FIFO is non-empty.
  - Clears to 0 on any compare, or when both FIFOs are empty.
  - Reaching TIMEOUT goes to FAIL with code 3.
- Error priority when several occur in the same cycle: mismatch > overflow > timeout.
- Capture on entering FAIL:
  - `err_*` registers capture the head entries present that cycle.
  - An empty side captures zeros.
  - `error` is set to 1.
- FAIL: no pushes, no pops. All outputs are frozen. FAIL is left only by `reset`.
- `match_count` saturates at 2^32-1 and does not wrap.

## Timing
- Reset values: `match_count`=0, `error`=0, `err_code`=0, all `err_*`=0, both levels=0, stall counter=0, state RUN.
- Reset has priority over any push or compare in the same cycle.
- Reset in the middle of a test empties both FIFOs on that edge.
- Push latency: an event pushed at edge N is at the FIFO head after edge N.
  - It may be compared (popped) at edge N+1.
  - `match_count` and `error` reflect that compare after edge N+1.
- Events pushed into both empty FIFOs in the same cycle show in `match_count` one cycle later.
- Back-to-back same-cycle pushes from both streams give one compare per cycle. Levels stay at most 1.
- Levels update on the edge of the push or pop. A simultaneous push and pop leaves the level unchanged.
- A timeout fires on the edge where the stall counter would reach TIMEOUT, i.e. TIMEOUT cycles after the first lone-occupied cycle.

## Test plan
- Matched streams: both sides push rd=5/0x1234 and then rd=7/0xdeadbeef in the same cycles.
  - Required: `match_count`=2 two cycles after the last push; `error`=0.
- Skewed streams: the dut side pushes 4 events in cycles 0–3, and the ref side pushes the same 4 in cycles 10–13.
  - Required: `dut_level` peaks at 4; `match_count`=4 after cycle 14; `error`=0.
- Mismatch on the third event: dut data 0x00000010 vs ref data 0x00000011, both rd=3.
  - Required: `err_code`=1, `err_index`=2, `err_dut_data`=0x10, `err_ref_data`=0x11.
  - All outputs stay frozen for 20 further cycles.
- Overflow: with DEPTH=8, push 9 dut events and no ref events.
  - Required: `err_code`=2 on the 9th push edge; `dut_level`=8.
- Timeout and x0 filtering: push 1 ref event with rd=0, then 1 dut event with rd=4, and nothing else.
  - Required: `ref_level` stays 0.
  - `err_code`=3 exactly 64 cycles after `dut_level` first becomes 1; `err_ref_rd`=0.
- Reset mid-FAIL: assert `reset` for 1 cycle.
  - Required: all outputs return to 0 and the state returns to RUN.
  - A subsequent matched pair gives `match_count`=1.
